// File: rtl/idct_block_sched.sv
// ============================================================================
// idct_block_sched
//
// Block-level scheduler in front of the row/column IDCT pipeline. It takes
// 8x8 coefficient blocks from upstream and starts the IDCT core. It feeds the
// core BLK_LEN contiguous coefficients per block and holds the per-block mode
// flag stable. It frames the core's pixel output into BLK_LEN-pixel blocks and
// caps the number of blocks that have been fed but not yet fully output.
//
// States:
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_IDLE  | waiting for upstream valid and a free in-flight slot
//   S_ARM   | one-cycle active-low start pulse to the core
//   S_FEED  | BLK_LEN beats to the core, one per cycle, in_ready high
//   S_DRAIN | waiting for the core's first-pixel pulse for this block
//
// Parameters:
//   DW            coefficient width
//   BLK_LEN       samples per block
//   MAX_INFLIGHT  blocks fed but not yet fully output (1..3)
//
// Ports:
//   clk             clock, all logic on posedge
//   rst_b           synchronous reset, active-high (1 = reset)
//   in_data         upstream coefficient
//   in_mode         upstream mode flag, sampled on beat 0 of a block
//   in_valid        upstream beat valid
//   in_ready        scheduler accepts beat (high only while feeding)
//   idct_start_b    active-low start/reset to the core (0 holds core idle)
//   idct_data       registered coefficient to the core
//   idct_mode       per-block mode flag to the core
//   idct_out_start  core first-pixel pulse
//   idct_pix        core pixel
//   pix_data        framed pixel
//   pix_valid       pixel valid
//   pix_last        last pixel of a block
//   blk_done        one-cycle pulse together with pix_last
//   err_gap         sticky: upstream gap inside a block
//   busy            blocks in flight or FSM not idle
//
// Optional feature (macro IDCT_SCHED_PERF_EN):
//   perf_blocks     completed-block counter, wraps
//   perf_stall      cycles with in_valid=1 and in_ready=0, saturates
// ============================================================================
module idct_block_sched #(
    parameter int DW           = 16,
    parameter int BLK_LEN      = 64,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [DW-1:0] in_data,
    input  logic          in_mode,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          idct_start_b,
    output logic [DW-1:0] idct_data,
    output logic          idct_mode,
    input  logic          idct_out_start,
    input  logic [7:0]    idct_pix,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    output logic          pix_last,
    output logic          blk_done,
    output logic          err_gap,
`ifdef IDCT_SCHED_PERF_EN
    output logic [15:0]   perf_blocks,
    output logic [15:0]   perf_stall,
`endif
    output logic          busy
);

    localparam int CW = $clog2(BLK_LEN);
    localparam int IW = 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(BLK_LEN - 1);
    localparam logic [IW-1:0] MAX_IF   = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_FEED  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic          core_en_q, core_en_d;
    logic          start_seen_q, start_seen_d;
    logic [DW-1:0] idct_data_q, idct_data_d;
    logic          idct_mode_q, idct_mode_d;
    logic          err_gap_q, err_gap_d;
    logic [IW-1:0] inflight_q, inflight_d;

    logic          out_active_q, out_active_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]    pix_data_q, pix_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic          pix_last_q, pix_last_d;
    logic          blk_done_q, blk_done_d;

    logic feeding;
    logic feed_last;
    logic done_evt;
    logic lost_evt;
    logic if_dec;
    logic arm_ok;
    logic arm_go;

    assign feeding   = (state_q == S_FEED);
    assign feed_last = feeding && (in_cnt_q == LAST_IDX);

    // A start pulse while a block is being framed restarts the count, so the
    // interrupted block never completes. It is released from the in-flight
    // count at that point, otherwise its slot would leak forever.
    assign done_evt = out_active_q && !idct_out_start && (pix_cnt_q == LAST_IDX);
    assign lost_evt = out_active_q && idct_out_start && (inflight_q != '0);
    assign if_dec   = done_evt || lost_evt;

    // A slot being freed on this very edge counts as free, so ARM and
    // blk_done may coincide and leave the count unchanged.
    assign arm_ok = (inflight_q < MAX_IF) || if_dec;
    assign arm_go = (state_q == S_IDLE) && in_valid && arm_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm_go) state_d = S_ARM;
            S_ARM:   state_d = S_FEED;
            S_FEED:  if (feed_last) state_d = S_DRAIN;
            // The core may raise its first-pixel pulse before the last beat
            // has been handed over; start_seen_q remembers that case.
            S_DRAIN: if (idct_out_start || start_seen_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        idct_start_b = 1'b0;
        busy         = (inflight_q != '0) || (state_q != S_IDLE);
        case (state_q)
            // After reset the core stays held until the first block arms.
            // Between blocks it must keep running so its pipeline can emit.
            S_IDLE:  idct_start_b = core_en_q;
            S_ARM:   idct_start_b = 1'b0;
            S_FEED: begin
                in_ready     = 1'b1;
                idct_start_b = 1'b1;
            end
            S_DRAIN: idct_start_b = 1'b1;
            default: idct_start_b = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Feed datapath, in-flight count, output framing
    // ------------------------------------------------------------------
    always_comb begin
        in_cnt_d     = feeding ? (in_cnt_q + 1'b1) : '0;
        core_en_d    = core_en_q | (state_q == S_ARM);

        start_seen_d = 1'b0;
        if (feeding) begin
            start_seen_d = start_seen_q | idct_out_start;
        end else if (state_q == S_DRAIN) begin
            start_seen_d = start_seen_q;
        end

        // Missing beats go to the core as zero so the block stays aligned.
        idct_data_d = '0;
        if (feeding && in_valid) begin
            idct_data_d = in_data;
        end

        idct_mode_d = idct_mode_q;
        if (feeding && (in_cnt_q == '0)) begin
            idct_mode_d = in_mode;
        end

        err_gap_d = err_gap_q | (feeding && !in_valid);

        inflight_d = inflight_q;
        if (arm_go && !if_dec) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!arm_go && if_dec) begin
            inflight_d = inflight_q - 1'b1;
        end

        out_active_d = out_active_q;
        pix_cnt_d    = pix_cnt_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        pix_last_d   = 1'b0;
        blk_done_d   = 1'b0;
        if (idct_out_start) begin
            // The start cycle carries no pixel; pixel 0 follows it.
            out_active_d = 1'b1;
            pix_cnt_d    = '0;
        end else if (out_active_q) begin
            pix_data_d  = idct_pix;
            pix_valid_d = 1'b1;
            pix_cnt_d   = pix_cnt_q + 1'b1;
            if (pix_cnt_q == LAST_IDX) begin
                pix_last_d   = 1'b1;
                blk_done_d   = 1'b1;
                out_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            in_cnt_q     <= '0;
            core_en_q    <= 1'b0;
            start_seen_q <= 1'b0;
            idct_data_q  <= '0;
            idct_mode_q  <= 1'b0;
            err_gap_q    <= 1'b0;
            inflight_q   <= '0;
            out_active_q <= 1'b0;
            pix_cnt_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            blk_done_q   <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            core_en_q    <= core_en_d;
            start_seen_q <= start_seen_d;
            idct_data_q  <= idct_data_d;
            idct_mode_q  <= idct_mode_d;
            err_gap_q    <= err_gap_d;
            inflight_q   <= inflight_d;
            out_active_q <= out_active_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
            blk_done_q   <= blk_done_d;
        end
    end

    // A completed block always corresponds to one that was fed.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            assert (!(done_evt && (inflight_q == '0)));
        end
    end

    assign idct_data = idct_data_q;
    assign idct_mode = idct_mode_q;
    assign err_gap   = err_gap_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign blk_done  = blk_done_q;

`ifdef IDCT_SCHED_PERF_EN
    logic [15:0] perf_blocks_q, perf_blocks_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_blocks_d = perf_blocks_q;
        if (done_evt) begin
            perf_blocks_d = perf_blocks_q + 16'd1;
        end
        perf_stall_d = perf_stall_q;
        if (in_valid && !in_ready && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_blocks_q <= perf_blocks_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_idct_block_sched.sv
// ============================================================================
// tb_idct_block_sched
//
// Self-checking bench for idct_block_sched. Stimulus tasks push the expected
// core-side beats and framed pixels into queues; a negedge monitor pops and
// compares whenever the DUT presents a beat or a pixel.
// ============================================================================
module tb_idct_block_sched;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [DW-1:0] in_data;
    logic          in_mode;
    logic          in_valid;
    logic          in_ready;
    logic          idct_start_b;
    logic [DW-1:0] idct_data;
    logic          idct_mode;
    logic          idct_out_start;
    logic [7:0]    idct_pix;
    logic [7:0]    pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic          blk_done;
    logic          err_gap;
    logic          busy;
`ifdef IDCT_SCHED_PERF_EN
    logic [15:0]   perf_blocks;
    logic [15:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    idct_block_sched #(.DW(DW), .BLK_LEN(64), .MAX_INFLIGHT(2)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .in_data        (in_data),
        .in_mode        (in_mode),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .idct_start_b   (idct_start_b),
        .idct_data      (idct_data),
        .idct_mode      (idct_mode),
        .idct_out_start (idct_out_start),
        .idct_pix       (idct_pix),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_last       (pix_last),
        .blk_done       (blk_done),
        .err_gap        (err_gap),
`ifdef IDCT_SCHED_PERF_EN
        .perf_blocks    (perf_blocks),
        .perf_stall     (perf_stall),
`endif
        .busy           (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [16:0] exp_feed[$];   // {coefficient, mode}
    logic [8:0]  exp_pix[$];    // {pixel, last}
    int          done_cyc[$];
    int          rise_cyc[$];

    int blocks_fed   = 0;
    int exp_done     = 0;
    int perf_exp     = 0;
    int n_done       = 0;
    int cyc          = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        ready_prev    = 1'b0;
    logic        in_ready_prev = 1'b0;
    logic        sb_prev       = 1'b0;
    logic        low_armed     = 1'b0;
    int          low_len       = 0;
    logic [16:0] ef;
    logic [8:0]  ep;

    always @(negedge clk) begin
        cyc++;
        if (ready_prev) begin
            if (exp_feed.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL feed_extra: got beat 0x%0h, expected no beat (cycle %0d)", idct_data, cyc);
            end else begin
                ef = exp_feed.pop_front();
                check("idct_data", 32'(idct_data), 32'(ef[16:1]));
                check("idct_mode", 32'(idct_mode), 32'(ef[0]));
            end
        end
        ready_prev = in_ready && !rst_b;

        if (pix_valid) begin
            if (exp_pix.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL pix_extra: got pixel 0x%0h, expected no pixel (cycle %0d)", pix_data, cyc);
            end else begin
                ep = exp_pix.pop_front();
                check("pix_data", 32'(pix_data), 32'(ep[8:1]));
                check("pix_last", 32'(pix_last), 32'(ep[0]));
                check("blk_done", 32'(blk_done), 32'(ep[0]));
            end
        end else if (!rst_b) begin
            check("flags_idle", 32'({pix_last, blk_done}), 32'd0);
        end
        if (blk_done) begin
            done_cyc.push_back(cyc);
            n_done++;
        end

        if (in_ready && !in_ready_prev && !rst_b) begin
            rise_cyc.push_back(cyc);
            check("start_b_arm", 32'(sb_prev), 32'd0);
            check("start_b_feed", 32'(idct_start_b), 32'd1);
        end
        in_ready_prev = in_ready;

        if (rst_b) begin
            low_armed = 1'b0;
        end else if (!idct_start_b && sb_prev) begin
            low_armed = 1'b1;
            low_len   = 1;
        end else if (!idct_start_b && low_armed) begin
            low_len++;
        end else if (idct_start_b && low_armed) begin
            check("start_b_low_len", 32'(low_len), 32'd1);
            low_armed = 1'b0;
        end
        sb_prev = idct_start_b;
    end

    // ------------------------------------------------------------------
    // Upstream driver: one block of 64 slots. A gap slot presents
    // in_valid=0; abort_at asserts reset in place of that slot.
    // ------------------------------------------------------------------
    task automatic feed_block(input bit mode, input bit use_index, input int gap_at, input int abort_at);
        int            slot  = 0;
        int            guard = 0;
        logic          r;
        logic [DW-1:0] d;
        while (slot < 64) begin
            if (slot == abort_at) begin
                in_valid = 1'b0;
                rst_b    = 1'b1;
                @(posedge clk); #1;
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_start_b", 32'(idct_start_b), 32'd0);
                check("abort_err_gap", 32'(err_gap), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                @(posedge clk); #1;
                rst_b    = 1'b0;
                perf_exp = 0;
                return;
            end
            d        = use_index ? DW'(slot) : (DW'($urandom) | DW'(1));
            in_data  = d;
            in_valid = (slot != gap_at);
            in_mode  = (slot == 0) ? mode : 1'($urandom_range(0, 1));
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            if (r) begin
                exp_feed.push_back({(slot == gap_at) ? DW'(0) : d, mode});
                slot++;
            end else if (++guard > 3000) begin
                check("feed_timeout", 32'(slot), 32'd64);
                break;
            end
        end
        in_valid = 1'b0;
        blocks_fed++;
    endtask

    task automatic wait_fed(input int n);
        int g = 0;
        while (blocks_fed < n && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check("wait_fed", 32'(blocks_fed >= n), 32'd1);
    endtask

    // Core emulator: first-pixel pulse, then npix pixels on following cycles.
    task automatic core_emit(input int npix, input bit use_index);
        logic [7:0] p;
        idct_out_start = 1'b1;
        @(posedge clk); #1;
        idct_out_start = 1'b0;
        for (int i = 0; i < npix; i++) begin
            p        = use_index ? 8'(i) : 8'($urandom);
            idct_pix = p;
            exp_pix.push_back({p, (i == 63)});
            @(posedge clk); #1;
        end
        idct_pix = 8'd0;
        if (npix == 64) begin
            exp_done++;
            perf_exp++;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((exp_pix.size() != 0 || exp_feed.size() != 0) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_bound", 32'(g < 3000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within bound");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int d0;
        int r0;
        int base;

        rst_b          = 1'b1;
        in_data        = '0;
        in_mode        = 1'b0;
        in_valid       = 1'b0;
        idct_out_start = 1'b0;
        idct_pix       = 8'd0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_start_b", 32'(idct_start_b), 32'd0);
        check("rst_idct_data", 32'(idct_data), 32'd0);
        check("rst_idct_mode", 32'(idct_mode), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_blk_done", 32'(blk_done), 32'd0);
        check("rst_err_gap", 32'(err_gap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_start_b_held", 32'(idct_start_b), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single block: data = index, mode 1, pixels 0..63
        fork
            feed_block(1'b1, 1'b1, -1, -1);
            begin
                wait_fed(1);
                check("drain_busy", 32'(busy), 32'd1);
                check("drain_in_ready", 32'(in_ready), 32'd0);
                repeat (4) @(posedge clk);
                #1;
                core_emit(64, 1'b1);
            end
        join
        wait_idle();
        check("single_busy_done", 32'(busy), 32'd0);
        check("single_err_gap", 32'(err_gap), 32'd0);
        check("single_mode_held", 32'(idct_mode), 32'd1);

        // Gap at beat 10, then a clean block: err_gap sticks
        base = blocks_fed;
        fork
            begin
                feed_block(1'b0, 1'b0, 10, -1);
                feed_block(1'b1, 1'b0, -1, -1);
            end
            begin
                wait_fed(base + 1);
                repeat (3) @(posedge clk);
                #1;
                check("gap_err_set", 32'(err_gap), 32'd1);
                core_emit(64, 1'b0);
                wait_fed(base + 2);
                core_emit(64, 1'b0);
            end
        join
        wait_idle();
        check("gap_err_sticky", 32'(err_gap), 32'd1);

        // Mode change back-to-back: A mode 0, B mode 1
        base = blocks_fed;
        fork
            begin
                feed_block(1'b0, 1'b0, -1, -1);
                feed_block(1'b1, 1'b0, -1, -1);
            end
            begin
                wait_fed(base + 1);
                repeat (2) @(posedge clk);
                #1;
                core_emit(64, 1'b0);
                wait_fed(base + 2);
                repeat (2) @(posedge clk);
                #1;
                core_emit(64, 1'b0);
            end
        join
        wait_idle();

        // Throttle: upstream always valid, core output delayed 200 cycles
        base = blocks_fed;
        d0   = done_cyc.size();
        r0   = rise_cyc.size();
        fork
            begin
                for (int k = 0; k < 3; k++) feed_block(1'($urandom_range(0, 1)), 1'b0, -1, -1);
            end
            begin
                for (int k = 1; k <= 3; k++) begin
                    wait_fed(base + k);
                    repeat (200) @(posedge clk);
                    #1;
                    core_emit(64, 1'b0);
                end
            end
        join
        wait_idle();
        if (done_cyc.size() > d0 && rise_cyc.size() > r0 + 2) begin
            check("throttle_order", 32'((rise_cyc[r0 + 2] - 1) >= done_cyc[d0]), 32'd1);
        end else begin
            check("throttle_events", 32'(rise_cyc.size() - r0), 32'd3);
        end
        check("throttle_busy_done", 32'(busy), 32'd0);

        // Randomised back-to-back blocks with random core latency
        base = blocks_fed;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    feed_block(1'($urandom_range(0, 1)), 1'b0,
                               ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 63)) : -1, -1);
                end
            end
            begin
                for (int k = 1; k <= 4; k++) begin
                    wait_fed(base + k);
                    repeat ($urandom_range(0, 20)) @(posedge clk);
                    #1;
                    core_emit(64, 1'b0);
                end
            end
        join
        wait_idle();

        // Restart: A's output interrupted by B's first-pixel pulse
        base = n_done;
        r0   = blocks_fed;
        fork
            begin
                feed_block(1'b0, 1'b0, -1, -1);
                feed_block(1'b1, 1'b0, -1, -1);
            end
            begin
                wait_fed(r0 + 1);
                repeat (2) @(posedge clk);
                #1;
                core_emit(20, 1'b0);
                core_emit(64, 1'b0);
            end
        join
        wait_idle();
        check("restart_one_done", 32'(n_done - base), 32'd1);
        check("restart_busy_done", 32'(busy), 32'd0);

        // Mid-block reset at beat 30, then a fresh block
        feed_block(1'b1, 1'b0, -1, 30);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_start_b", 32'(idct_start_b), 32'd0);
        check("post_rst_err_gap", 32'(err_gap), 32'd0);
        base = blocks_fed;
        fork
            feed_block(1'b0, 1'b1, -1, -1);
            begin
                wait_fed(base + 1);
                repeat (5) @(posedge clk);
                #1;
                core_emit(64, 1'b1);
            end
        join
        wait_idle();
        check("final_busy", 32'(busy), 32'd0);

        check("feed_queue_empty", 32'(exp_feed.size()), 32'd0);
        check("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
        check("blocks_done_total", 32'(n_done), 32'(exp_done));
`ifdef IDCT_SCHED_PERF_EN
        check("perf_blocks", 32'(perf_blocks), 32'(perf_exp));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
